main_dec_pipe: RTL and testbench
================================

// Module: main_dec_pipe
// PURPOSE
//  Parametrised successor to the single-cycle main decoder. Decodes the D-stage opcode into a
//  control bundle and carries it through the E/M/W pipeline registers, with stall/flush bubbles.
//  Adds the extended I-type/branch set (ORI, ANDI, SLTI, BNE) and a saturating illegal-opcode counter.
//  Sits between the IF/ID register and the datapath; replaces the per-stage control flops in the pipeline top.
// PARAMETERS
//  OP_W       6  opcode width
//  ALU_OP_W   3  alu_op width; 2 = legacy encoding, only base ops legal
//  EXT_EN     1  1 = ORI/ANDI/SLTI/BNE decoded; 0 = they are illegal (needs ALU_OP_W>=3 when 1)
//  ILL_CNT_W  8  illegal-opcode counter width
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         asynchronous, active-high; clears all state
//  op_d         in   OP_W      D-stage opcode
//  valid_d      in   1         op_d holds a real instruction
//  stall_d      in   1         hazard unit holds D; bubble into E
//  flush_e      in   1         kill instruction entering E (taken branch/jump); bubble into E
//  ill_clr      in   1         synchronous clear of ill_cnt
//  branch_d     out  1         comb: BEQ or BNE at D (early branch resolution)
//  branch_ne_d  out  1         comb: BNE at D
//  jump_d       out  1         comb: J or JAL at D
//  valid_e      out  1         E holds a real instruction
//  reg_write_e, reg_dst_e, alu_src_e, mem_write_e, mem_to_reg_e, jal_e, zero_ext_e  out 1 each
//  alu_op_e     out  ALU_OP_W  E-stage ALU operation
//  illegal_e    out  1         E holds an undecodable opcode (controls forced 0)
//  reg_write_m, mem_write_m, mem_to_reg_m, jal_m   out 1 each  M-stage copies
//  reg_write_w, mem_to_reg_w, jal_w                out 1 each  W-stage copies
//  ill_cnt      out  ILL_CNT_W illegal opcodes accepted into E, saturating
// BEHAVIOUR
//  Decode (comb, only when valid_d): [reg_write reg_dst alu_src branch mem_write mem_to_reg jump jal], alu_op
//   000000 R:    1 1 0 0 0 0 0 0  FUNCT      100011 LW:  1 0 1 0 0 1 0 0  ADD
//   101011 SW:   0 0 1 0 1 0 0 0  ADD        000100 BEQ: 0 0 0 1 0 0 0 0  SUB
//   001000 ADDI: 1 0 1 0 0 0 0 0  ADD        000010 J:   0 0 0 0 0 0 1 0  ADD
//   000011 JAL:  1 0 0 0 0 0 1 1  ADD
//   EXT_EN only: 001101 ORI 1 0 1 0 0 0 0 0 OR, zero_ext=1 | 001100 ANDI same, AND, zero_ext=1
//                001010 SLTI 1 0 1 0 0 0 0 0 SLT | 000101 BNE 0 0 0 1 0 0 0 0 SUB, branch_ne=1
//  alu_op codes: ADD=0 SUB=1 FUNCT=2 OR=3 AND=4 SLT=5; ALU_OP_W=2 uses ADD=00 SUB=01 FUNCT=10.
//  Any other opcode with valid_d=1: illegal; all controls 0, illegal flag 1.
//  valid_d=0: D outputs 0, no decode.
//  E capture every clk: if stall_d|flush_e|!valid_d -> bubble (valid_e=0, all E outputs 0, illegal_e=0);
//   else E <= decoded bundle, valid_e=1. Latency: D decode -> E +1 clk -> M +2 -> W +3.
//  M <= E and W <= M unconditionally every clk; bubbles propagate as all-zero controls.
//  Invariant: mem_write_* and reg_write_* are never 1 for a bubble or illegal op.
//  ill_cnt: +1 when an illegal op is captured into E; holds at all-ones. ill_clr wins over increment (-> 0).
//  stall_d & flush_e together: single bubble, no count.
//  Reset (any time, async): every registered output, valid_e, illegal_e, ill_cnt = 0; comb D outputs still
//   follow op_d. First capture on the first rising clk after reset deasserts.
// STRUCTURE
//  main_dec_pkg: opcode localparams, ALU_OP codes, control-bundle field offsets and width.
//  Sub-module main_dec_comb: pure combinational decode (op_d, valid_d -> bundle, illegal); this module
//   holds the E/M/W registers and ill_cnt only.
// TESTING
//  1 Reset: hold reset, toggle clk -> all E/M/W outputs and ill_cnt 0; assert reset mid-stream -> cleared same cycle.
//  2 LW op 100011 valid -> E next clk: reg_write=1 alu_src=1 mem_to_reg=1 alu_op=0; mem_to_reg_m +2, mem_to_reg_w +3.
//  3 SW with stall_d=1 for 2 clks then 0 -> two bubbles (mem_write_e=0, valid_e=0), then mem_write_e=1 once.
//  4 BNE 000101 -> branch_d=1 branch_ne_d=1 comb; with flush_e=1 same cycle -> E bubble, no count.
//  5 EXT_EN=0: ORI 001101 -> illegal_e=1, all controls 0, ill_cnt=1; ILL_CNT_W=2, 5 illegals -> ill_cnt=3; ill_clr -> 0.
//  6 JAL 000011 -> jump_d=1; E reg_write=1 jal=1; jal_w=1 and reg_write_w=1 exactly 3 clks after D.

Source files
------------

// File: rtl/main_dec_pkg.sv
// Shared definitions for the pipelined main decoder.
//  - Opcode values of the base and extended instruction sets.
//  - ALU operation codes (3-bit internal form; narrower ALU_OP_W truncates).
//  - Bit offsets of the control bundle carried from D into E.
package main_dec_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // Legacy 2-bit codes are the low bits of the first three entries.
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    // Control bundle layout, MSB first in the same order as the decode table.
    localparam int CTL_W          = 10;
    localparam int CTL_REG_WRITE  = 9;
    localparam int CTL_REG_DST    = 8;
    localparam int CTL_ALU_SRC    = 7;
    localparam int CTL_BRANCH     = 6;
    localparam int CTL_MEM_WRITE  = 5;
    localparam int CTL_MEM_TO_REG = 4;
    localparam int CTL_JUMP       = 3;
    localparam int CTL_JAL        = 2;
    localparam int CTL_ZERO_EXT   = 1;
    localparam int CTL_BRANCH_NE  = 0;

    // base = {reg_write reg_dst alu_src branch mem_write mem_to_reg jump jal}
    function automatic logic [CTL_W-1:0] mk_ctl(input logic [7:0] base,
                                                input logic zero_ext,
                                                input logic branch_ne);
        return {base, zero_ext, branch_ne};
    endfunction

endpackage

// File: rtl/main_dec_comb.sv
// Pure combinational opcode decode.
//  op_d, valid_d  : D-stage opcode and its valid qualifier
//  ctl            : control bundle (layout in main_dec_pkg)
//  alu_op         : ALU operation, ALU_OP_W bits
//  illegal        : valid opcode that is not in the decoded set (ctl forced 0)
module main_dec_comb
    import main_dec_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter bit EXT_EN   = 1'b1
) (
    input  logic [OP_W-1:0]     op_d,
    input  logic                valid_d,
    output logic [CTL_W-1:0]    ctl,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal
);

    logic [2:0] alu3;

    always_comb begin
        ctl     = '0;
        alu3    = ALU_ADD;
        illegal = 1'b0;
        if (valid_d) begin
            case (op_d)
                OP_W'(OP_RTYPE): begin ctl = mk_ctl(8'b1100_0000, 1'b0, 1'b0); alu3 = ALU_FUNCT; end
                OP_W'(OP_LW):    ctl = mk_ctl(8'b1010_0100, 1'b0, 1'b0);
                OP_W'(OP_SW):    ctl = mk_ctl(8'b0010_1000, 1'b0, 1'b0);
                OP_W'(OP_BEQ):   begin ctl = mk_ctl(8'b0001_0000, 1'b0, 1'b0); alu3 = ALU_SUB; end
                OP_W'(OP_ADDI):  ctl = mk_ctl(8'b1010_0000, 1'b0, 1'b0);
                OP_W'(OP_J):     ctl = mk_ctl(8'b0000_0010, 1'b0, 1'b0);
                OP_W'(OP_JAL):   ctl = mk_ctl(8'b1000_0011, 1'b0, 1'b0);
                OP_W'(OP_ORI): begin
                    if (EXT_EN) begin ctl = mk_ctl(8'b1010_0000, 1'b1, 1'b0); alu3 = ALU_OR; end
                    else illegal = 1'b1;
                end
                OP_W'(OP_ANDI): begin
                    if (EXT_EN) begin ctl = mk_ctl(8'b1010_0000, 1'b1, 1'b0); alu3 = ALU_AND; end
                    else illegal = 1'b1;
                end
                OP_W'(OP_SLTI): begin
                    if (EXT_EN) begin ctl = mk_ctl(8'b1010_0000, 1'b0, 1'b0); alu3 = ALU_SLT; end
                    else illegal = 1'b1;
                end
                OP_W'(OP_BNE): begin
                    if (EXT_EN) begin ctl = mk_ctl(8'b0001_0000, 1'b0, 1'b1); alu3 = ALU_SUB; end
                    else illegal = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    // With ALU_OP_W=2 only ADD/SUB/FUNCT can be produced, which fit in 2 bits.
    assign alu_op = ALU_OP_W'(alu3);

endmodule

// File: rtl/main_dec_pipe.sv
// Pipelined main decoder: decodes the D-stage opcode and carries the control
// bundle through the E, M and W pipeline registers.
//  clk, reset            : clock, async active-high reset
//  op_d, valid_d         : D-stage opcode and qualifier
//  stall_d, flush_e      : either one inserts a bubble into E
//  ill_clr               : synchronous clear of ill_cnt (wins over increment)
//  branch_d/branch_ne_d/jump_d : combinational D-stage branch/jump flags
//  *_e / *_m / *_w       : registered per-stage controls
//  ill_cnt               : saturating count of illegal ops accepted into E
module main_dec_pipe
    import main_dec_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int ALU_OP_W  = 3,
    parameter bit EXT_EN    = 1'b1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op_d,
    input  logic                 valid_d,
    input  logic                 stall_d,
    input  logic                 flush_e,
    input  logic                 ill_clr,
    output logic                 branch_d,
    output logic                 branch_ne_d,
    output logic                 jump_d,
    output logic                 valid_e,
    output logic                 reg_write_e,
    output logic                 reg_dst_e,
    output logic                 alu_src_e,
    output logic                 mem_write_e,
    output logic                 mem_to_reg_e,
    output logic                 jal_e,
    output logic                 zero_ext_e,
    output logic [ALU_OP_W-1:0]  alu_op_e,
    output logic                 illegal_e,
    output logic                 reg_write_m,
    output logic                 mem_write_m,
    output logic                 mem_to_reg_m,
    output logic                 jal_m,
    output logic                 reg_write_w,
    output logic                 mem_to_reg_w,
    output logic                 jal_w,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    logic [CTL_W-1:0]    ctl_dec;
    logic [ALU_OP_W-1:0] alu_dec;
    logic                ill_dec;

    main_dec_comb #(.OP_W(OP_W), .ALU_OP_W(ALU_OP_W), .EXT_EN(EXT_EN)) u_dec (
        .op_d    (op_d),
        .valid_d (valid_d),
        .ctl     (ctl_dec),
        .alu_op  (alu_dec),
        .illegal (ill_dec)
    );

    assign branch_d    = ctl_dec[CTL_BRANCH];
    assign branch_ne_d = ctl_dec[CTL_BRANCH_NE];
    assign jump_d      = ctl_dec[CTL_JUMP];

    logic [CTL_W-1:0]     ctl_e_d, ctl_e_q;
    logic [ALU_OP_W-1:0]  alu_e_d, alu_e_q;
    logic                 valid_e_d, valid_e_q;
    logic                 ill_e_d, ill_e_q;
    logic [3:0]           ctl_m_d, ctl_m_q;   // {reg_write, mem_write, mem_to_reg, jal}
    logic [2:0]           ctl_w_d, ctl_w_q;   // {reg_write, mem_to_reg, jal}
    logic [ILL_CNT_W-1:0] ill_cnt_d, ill_cnt_q;
    logic                 capture;

    always_comb begin
        // stall and flush together still produce just one bubble, and a
        // bubble is never counted as illegal.
        capture   = valid_d & ~stall_d & ~flush_e;
        ctl_e_d   = '0;
        alu_e_d   = '0;
        valid_e_d = 1'b0;
        ill_e_d   = 1'b0;
        if (capture) begin
            ctl_e_d   = ctl_dec;
            alu_e_d   = alu_dec;
            valid_e_d = 1'b1;
            ill_e_d   = ill_dec;
        end

        ctl_m_d = {ctl_e_q[CTL_REG_WRITE], ctl_e_q[CTL_MEM_WRITE],
                   ctl_e_q[CTL_MEM_TO_REG], ctl_e_q[CTL_JAL]};
        ctl_w_d = {ctl_m_q[3], ctl_m_q[1], ctl_m_q[0]};

        ill_cnt_d = ill_cnt_q;
        if (ill_clr)
            ill_cnt_d = '0;
        else if (capture && ill_dec && !(&ill_cnt_q))
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_e_q   <= '0;
            alu_e_q   <= '0;
            valid_e_q <= 1'b0;
            ill_e_q   <= 1'b0;
            ctl_m_q   <= '0;
            ctl_w_q   <= '0;
            ill_cnt_q <= '0;
        end else begin
            ctl_e_q   <= ctl_e_d;
            alu_e_q   <= alu_e_d;
            valid_e_q <= valid_e_d;
            ill_e_q   <= ill_e_d;
            ctl_m_q   <= ctl_m_d;
            ctl_w_q   <= ctl_w_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign valid_e      = valid_e_q;
    assign reg_write_e  = ctl_e_q[CTL_REG_WRITE];
    assign reg_dst_e    = ctl_e_q[CTL_REG_DST];
    assign alu_src_e    = ctl_e_q[CTL_ALU_SRC];
    assign mem_write_e  = ctl_e_q[CTL_MEM_WRITE];
    assign mem_to_reg_e = ctl_e_q[CTL_MEM_TO_REG];
    assign jal_e        = ctl_e_q[CTL_JAL];
    assign zero_ext_e   = ctl_e_q[CTL_ZERO_EXT];
    assign alu_op_e     = alu_e_q;
    assign illegal_e    = ill_e_q;

    assign reg_write_m  = ctl_m_q[3];
    assign mem_write_m  = ctl_m_q[2];
    assign mem_to_reg_m = ctl_m_q[1];
    assign jal_m        = ctl_m_q[0];

    assign reg_write_w  = ctl_w_q[2];
    assign mem_to_reg_w = ctl_w_q[1];
    assign jal_w        = ctl_w_q[0];

    assign ill_cnt      = ill_cnt_q;

endmodule

// File: tb/tb_main_dec_pipe.sv
module tb_main_dec_pipe;

    logic       clk = 1'b0;
    logic       reset, valid_d, stall_d, flush_e, ill_clr;
    logic [5:0] op_d;

    always #5 clk = ~clk;

    // Default-parameter instance (extended set, 3-bit alu_op, 8-bit counter)
    logic       branch_d, branch_ne_d, jump_d, valid_e, reg_write_e, reg_dst_e, alu_src_e;
    logic       mem_write_e, mem_to_reg_e, jal_e, zero_ext_e, illegal_e;
    logic [2:0] alu_op_e;
    logic       reg_write_m, mem_write_m, mem_to_reg_m, jal_m, reg_write_w, mem_to_reg_w, jal_w;
    logic [7:0] ill_cnt;

    main_dec_pipe dut (
        .clk(clk), .reset(reset), .op_d(op_d), .valid_d(valid_d), .stall_d(stall_d),
        .flush_e(flush_e), .ill_clr(ill_clr), .branch_d(branch_d), .branch_ne_d(branch_ne_d),
        .jump_d(jump_d), .valid_e(valid_e), .reg_write_e(reg_write_e), .reg_dst_e(reg_dst_e),
        .alu_src_e(alu_src_e), .mem_write_e(mem_write_e), .mem_to_reg_e(mem_to_reg_e),
        .jal_e(jal_e), .zero_ext_e(zero_ext_e), .alu_op_e(alu_op_e), .illegal_e(illegal_e),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m),
        .jal_m(jal_m), .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w), .jal_w(jal_w),
        .ill_cnt(ill_cnt)
    );

    // Legacy instance: base set only, 2-bit alu_op, 2-bit counter
    logic       l_branch_d, l_branch_ne_d, l_jump_d, l_valid_e, l_reg_write_e, l_reg_dst_e, l_alu_src_e;
    logic       l_mem_write_e, l_mem_to_reg_e, l_jal_e, l_zero_ext_e, l_illegal_e;
    logic [1:0] l_alu_op_e;
    logic       l_reg_write_m, l_mem_write_m, l_mem_to_reg_m, l_jal_m, l_reg_write_w, l_mem_to_reg_w, l_jal_w;
    logic [1:0] l_ill_cnt;

    main_dec_pipe #(.OP_W(6), .ALU_OP_W(2), .EXT_EN(1'b0), .ILL_CNT_W(2)) dut_l (
        .clk(clk), .reset(reset), .op_d(op_d), .valid_d(valid_d), .stall_d(stall_d),
        .flush_e(flush_e), .ill_clr(ill_clr), .branch_d(l_branch_d), .branch_ne_d(l_branch_ne_d),
        .jump_d(l_jump_d), .valid_e(l_valid_e), .reg_write_e(l_reg_write_e), .reg_dst_e(l_reg_dst_e),
        .alu_src_e(l_alu_src_e), .mem_write_e(l_mem_write_e), .mem_to_reg_e(l_mem_to_reg_e),
        .jal_e(l_jal_e), .zero_ext_e(l_zero_ext_e), .alu_op_e(l_alu_op_e), .illegal_e(l_illegal_e),
        .reg_write_m(l_reg_write_m), .mem_write_m(l_mem_write_m), .mem_to_reg_m(l_mem_to_reg_m),
        .jal_m(l_jal_m), .reg_write_w(l_reg_write_w), .mem_to_reg_w(l_mem_to_reg_w), .jal_w(l_jal_w),
        .ill_cnt(l_ill_cnt)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // d = {branch, branch_ne, jump}; ctl = {rw, rd, as, mw, m2r, jal, zx}
    typedef struct {
        logic [5:0] op;
        logic       vld, stall, flush;
        logic [2:0] d;
        logic [6:0] ctl;
        logic [2:0] alu;
        logic       ve, ill;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [6:0] e_ctl();
        return {reg_write_e, reg_dst_e, alu_src_e, mem_write_e, mem_to_reg_e, jal_e, zero_ext_e};
    endfunction

    function automatic logic [31:0] all_regs();
        return {valid_e, e_ctl(), alu_op_e, illegal_e, reg_write_m, mem_write_m, mem_to_reg_m,
                jal_m, reg_write_w, mem_to_reg_w, jal_w, ill_cnt};
    endfunction

    initial begin
        vecs[0]  = '{6'b000000, 1, 0, 0, 3'b000, 7'b1100000, 3'd2, 1, 0}; // R
        vecs[1]  = '{6'b100011, 1, 0, 0, 3'b000, 7'b1010100, 3'd0, 1, 0}; // LW
        vecs[2]  = '{6'b101011, 1, 0, 0, 3'b000, 7'b0011000, 3'd0, 1, 0}; // SW
        vecs[3]  = '{6'b000100, 1, 0, 0, 3'b100, 7'b0000000, 3'd1, 1, 0}; // BEQ
        vecs[4]  = '{6'b001000, 1, 0, 0, 3'b000, 7'b1010000, 3'd0, 1, 0}; // ADDI
        vecs[5]  = '{6'b000010, 1, 0, 0, 3'b001, 7'b0000000, 3'd0, 1, 0}; // J
        vecs[6]  = '{6'b000011, 1, 0, 0, 3'b001, 7'b1000010, 3'd0, 1, 0}; // JAL
        vecs[7]  = '{6'b001101, 1, 0, 0, 3'b000, 7'b1010001, 3'd3, 1, 0}; // ORI
        vecs[8]  = '{6'b001100, 1, 0, 0, 3'b000, 7'b1010001, 3'd4, 1, 0}; // ANDI
        vecs[9]  = '{6'b001010, 1, 0, 0, 3'b000, 7'b1010000, 3'd5, 1, 0}; // SLTI
        vecs[10] = '{6'b000101, 1, 0, 0, 3'b110, 7'b0000000, 3'd1, 1, 0}; // BNE
        vecs[11] = '{6'b111111, 1, 0, 0, 3'b000, 7'b0000000, 3'd0, 1, 1}; // illegal
        vecs[12] = '{6'b100011, 0, 0, 0, 3'b000, 7'b0000000, 3'd0, 0, 0}; // not valid
        vecs[13] = '{6'b100011, 1, 1, 0, 3'b000, 7'b0000000, 3'd0, 0, 0}; // LW stalled
        vecs[14] = '{6'b000101, 1, 0, 1, 3'b110, 7'b0000000, 3'd0, 0, 0}; // BNE flushed
        vecs[15] = '{6'b111111, 1, 1, 1, 3'b000, 7'b0000000, 3'd0, 0, 0}; // illegal, stall+flush

        // ---- reset held while clocking
        reset = 1; op_d = 6'b100011; valid_d = 1; stall_d = 0; flush_e = 0; ill_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_regs", all_regs(), 32'd0);
        chk("reset_legacy_cnt", {30'd0, l_ill_cnt}, 32'd0);
        reset = 0; valid_d = 0;

        // ---- table
        foreach (vecs[i]) begin
            op_d = vecs[i].op; valid_d = vecs[i].vld; stall_d = vecs[i].stall; flush_e = vecs[i].flush;
            #1;
            chk($sformatf("d_out[%0d]", i), {29'd0, branch_d, branch_ne_d, jump_d}, {29'd0, vecs[i].d});
            tick();
            chk($sformatf("e_out[%0d]", i), {19'd0, e_ctl(), alu_op_e, valid_e, illegal_e},
                {19'd0, vecs[i].ctl, vecs[i].alu, vecs[i].ve, vecs[i].ill});
        end
        chk("ill_cnt_after_table", {24'd0, ill_cnt}, 32'd1);
        // legacy saw ORI, ANDI, SLTI, BNE, 111111 captured: 5 illegals saturate at 3
        chk("legacy_cnt_saturated", {30'd0, l_ill_cnt}, 32'd3);
        chk("legacy_bne_not_branch", {31'd0, l_branch_d}, 32'd0);
        valid_d = 0; stall_d = 0; flush_e = 0;

        // ---- LW latency through M and W
        ill_clr = 1; tick(); ill_clr = 0;
        chk("ill_clr", {24'd0, ill_cnt}, 32'd0);
        op_d = 6'b100011; valid_d = 1;
        tick(); valid_d = 0;
        chk("lw_e", {28'd0, reg_write_e, alu_src_e, mem_to_reg_e, alu_op_e == 3'd0}, 32'hF);
        tick();
        chk("lw_m", {30'd0, mem_to_reg_m, mem_to_reg_e}, 32'b10);
        tick();
        chk("lw_w", {30'd0, mem_to_reg_w, reg_write_w}, 32'b11);
        tick();
        chk("lw_w_gone", {31'd0, mem_to_reg_w}, 32'd0);

        // ---- SW with two stall cycles
        op_d = 6'b101011; valid_d = 1; stall_d = 1;
        tick(); chk("sw_stall1", {30'd0, mem_write_e, valid_e}, 32'd0);
        tick(); chk("sw_stall2", {30'd0, mem_write_e, valid_e}, 32'd0);
        stall_d = 0;
        tick(); chk("sw_go", {30'd0, mem_write_e, valid_e}, 32'b11);
        valid_d = 0;
        tick(); chk("sw_once", {30'd0, mem_write_e, mem_write_m}, 32'b01);

        // ---- JAL: controls reach W exactly 3 clocks after D
        op_d = 6'b000011; valid_d = 1;
        #1 chk("jal_jump_d", {31'd0, jump_d}, 32'd1);
        tick(); valid_d = 0;
        chk("jal_e", {30'd0, reg_write_e, jal_e}, 32'b11);
        tick();
        chk("jal_m_not_w", {30'd0, jal_m, jal_w}, 32'b10);
        tick();
        chk("jal_w", {30'd0, jal_w, reg_write_w}, 32'b11);

        // ---- async reset mid-stream
        op_d = 6'b100011; valid_d = 1;
        tick(); tick();
        op_d = 6'b000011;
        #2 reset = 1;
        #1;
        chk("midreset_regs", all_regs(), 32'd0);
        chk("midreset_comb", {31'd0, jump_d}, 32'd1);
        #1 reset = 0; valid_d = 0;

        // ---- legacy: ORI is illegal, counter saturates at 3, clear wins
        op_d = 6'b001101; valid_d = 1;
        tick();
        chk("leg_ori_e", {24'd0, l_illegal_e, l_valid_e, l_reg_write_e, l_alu_src_e,
                          l_zero_ext_e, l_mem_write_e, l_alu_op_e}, 32'b1100_0000);
        chk("leg_ori_cnt", {30'd0, l_ill_cnt}, 32'd1);
        chk("ext_ori_legal", {29'd0, illegal_e, zero_ext_e, ill_cnt == 8'd0}, 32'b011);
        repeat (4) tick();
        chk("leg_sat", {30'd0, l_ill_cnt}, 32'd3);
        ill_clr = 1;
        tick();
        chk("leg_clr_wins", {30'd0, l_ill_cnt}, 32'd0);
        ill_clr = 0;
        tick();
        chk("leg_recount", {30'd0, l_ill_cnt}, 32'd1);
        valid_d = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
